audio_nios_cpu_oci_dct_packer: RTL and testbench
================================================

// Module: audio_nios_cpu_oci_dct_packer
// PURPOSE
//  Write side of the OCI data-trace capture path. Packs 2-bit trace symbols into
//  30-bit frames: dct_buffer carries the symbols and dct_count gives the number
//  of valid entries, 0..15. Sits between the CPU trace tap and the trace FIFO.
//  Its frame output is the consumer interface seen by the OCI test bench.
// PARAMETERS
//  SYM_W    2   bits per trace symbol
//  DEPTH    15  symbols per full frame (DEPTH*SYM_W = 30)
//  CNT_W    4   width of dct_count
// PORTS
//  clk          in   1   single clock; all logic rising-edge
//  reset        in   1   synchronous, active-high reset
//  sym_valid    in   1   trace symbol present this cycle
//  sym_data     in   2   trace symbol
//  flush        in   1   one-cycle pulse: close the partial frame
//  frame_ready  in   1   downstream accepts the frame
//  frame_valid  out  1   dct_buffer/dct_count hold a frame
//  dct_buffer   out  30  packed symbols, newest symbol in [1:0]
//  dct_count    out  4   valid symbol count in dct_buffer
//  overflow     out  1   sticky: a symbol was dropped
// BEHAVIOUR
//  - Reset: frame_valid=0, dct_buffer=0, dct_count=0, overflow=0.
//    Accumulator, acc_count and flush_pend are cleared.
//  - Reset asserted mid-frame discards the partial frame and any held frame.
//    A held frame is discarded even if frame_ready is high that cycle.
//  - Accumulator acc[29:0] and acc_count[3:0] are separate from the output register.
//  - Accept: sym_valid && acc_count<15 -> acc<={acc[27:0],sym_data}, acc_count+1.
//    Valid symbols occupy [2*cnt-1:0]; upper bits are always 0.
//  - Drop: sym_valid && acc_count==15 (transfer blocked) -> symbol lost, overflow<=1.
//  - flush with acc_count_next==0 is ignored. Otherwise it sets flush_pend.
//    flush_pend clears on transfer.
//  - A symbol in the flush cycle is included in the flushed frame when it fits.
//  - close = (acc_count_next==15) || flush || flush_pend, with acc_count_next>0.
//  - slot_free = !frame_valid || frame_ready.
//  - Transfer (close && slot_free):
//    dct_buffer<=acc_next, dct_count<=acc_count_next, frame_valid<=1.
//    The accumulator clears to 0 and acc_count to 0.
//  - Transfer latency: frame_valid rises the cycle after the completing symbol or flush.
//  - Back-to-back: frame_ready with a new transfer in the same cycle gives no gap.
//    frame_valid stays 1 and the data updates.
//  - frame_ready without a new transfer: frame_valid<=0 next cycle.
//  - Output stays stable while frame_valid && !frame_ready.
//  - FSM (frame_valid x acc state): EMPTY, FILLING, FULL_WAIT.
//    EMPTY -> FILLING on the first accepted symbol.
//    FILLING -> FULL_WAIT when count reaches 15 with the slot busy.
//    FULL_WAIT -> EMPTY on transfer.
//  - overflow clears only on reset.
// CONFIGURATION
//  DCT_PACK_STATS_EN defined:
//    - Adds output drop_count[15:0], reset 0, +1 per dropped symbol, saturating at 16'hFFFF.
//    - Adds output frame_total[15:0], +1 per transfer, wrapping.
//  DCT_PACK_STATS_EN undefined: both ports and counters are absent.
//    overflow behaviour is unchanged either way.
// TESTING
//  1. Reset, then 15 symbols 2'b01..(cycling 0-3), frame_ready=1.
//     Expect frame_valid 1 cycle after the 15th symbol, dct_count=15.
//     Expect dct_buffer = symbols in order, newest in [1:0].
//  2. 3 symbols 2'b11,2'b10,2'b01 then flush.
//     Expect dct_count=3, dct_buffer=30'h39, one frame_valid pulse.
//  3. frame_ready=0: 30 symbols then 1 extra.
//     First frame is held stable and the second fills the accumulator.
//     Extra symbol is dropped and overflow=1.
//     Then frame_ready=1: two frames emitted back-to-back, no gap.
//  4. flush with empty accumulator -> no frame_valid.
//     Symbol and flush in the same cycle -> frame with dct_count=1.
//  5. Assert reset with 7 symbols accumulated and a frame held.
//     Expect all outputs 0 next cycle; the next flush yields no frame.
//  6. With DCT_PACK_STATS_EN: drop 3 symbols and emit 4 frames.
//     Expect drop_count=3, frame_total=4.

Source files
------------

// File: rtl/audio_nios_cpu_oci_dct_packer.sv
// audio_nios_cpu_oci_dct_packer: packs 2-bit trace symbols into 30-bit frames; DCT_PACK_STATS_EN adds drop/frame counters
module audio_nios_cpu_oci_dct_packer #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 15,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sym_valid,
  input  logic [SYM_W-1:0]       sym_data,
  input  logic                   flush,
  input  logic                   frame_ready,
  output logic                   frame_valid,
  output logic [DEPTH*SYM_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]       dct_count,
`ifdef DCT_PACK_STATS_EN
  output logic [15:0]            drop_count,
  output logic [15:0]            frame_total,
`endif
  output logic                   overflow
);
  localparam int W = DEPTH*SYM_W;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL_WAIT} state_t;
  state_t state, state_next;
  logic [W-1:0] acc, acc_next;
  logic [CNT_W-1:0] acc_count, cnt_next;
  logic flush_pend, accept, drop, close, slot_free, xfer;
  // next accumulator contents, frame close and transfer decision
  always_comb begin
    accept = sym_valid && state != FULL_WAIT;
    drop = sym_valid && state == FULL_WAIT;
    acc_next = accept ? {acc[W-SYM_W-1:0], sym_data} : acc;
    cnt_next = acc_count + {{(CNT_W-1){1'b0}}, accept};
    close = cnt_next != '0 && (cnt_next == CNT_W'(DEPTH) || flush || flush_pend);
    slot_free = !frame_valid || frame_ready;
    xfer = close && slot_free;
    state_next = xfer ? EMPTY : cnt_next == CNT_W'(DEPTH) ? FULL_WAIT : cnt_next != '0 ? FILLING : EMPTY;
  end
  // accumulator, output frame register and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      acc <= '0;
      acc_count <= '0;
      flush_pend <= 1'b0;
      frame_valid <= 1'b0;
      dct_buffer <= '0;
      dct_count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      acc <= xfer ? '0 : acc_next;
      acc_count <= xfer ? '0 : cnt_next;
      flush_pend <= xfer ? 1'b0 : flush_pend || (flush && cnt_next != '0);
      frame_valid <= xfer || (frame_valid && !frame_ready);
      if (xfer) begin
        dct_buffer <= acc_next;
        dct_count <= cnt_next;
      end
      if (drop) overflow <= 1'b1;
    end
  end
`ifdef DCT_PACK_STATS_EN
  // saturating drop counter and wrapping transfer counter
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
      frame_total <= '0;
    end else begin
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (xfer) frame_total <= frame_total + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_audio_nios_cpu_oci_dct_packer.sv
// tb_audio_nios_cpu_oci_dct_packer: table-driven and sequence checks of the trace packer
module tb_audio_nios_cpu_oci_dct_packer;
  logic clk = 1'b0, reset, sym_valid, flush, frame_ready, frame_valid, overflow;
  logic [1:0] sym_data;
  logic [29:0] dct_buffer;
  logic [3:0] dct_count;
`ifdef DCT_PACK_STATS_EN
  logic [15:0] drop_count, frame_total;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  audio_nios_cpu_oci_dct_packer dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data),
    .flush(flush), .frame_ready(frame_ready), .frame_valid(frame_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
`ifdef DCT_PACK_STATS_EN
    .drop_count(drop_count), .frame_total(frame_total),
`endif
    .overflow(overflow)
  );
  typedef struct {
    logic rst, sv;
    logic [1:0] sd;
    logic fl, fr, fv;
    logic [29:0] buff;
    logic [3:0] cnt;
    logic ovf;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic sv, input logic [1:0] sd, input logic fl, input logic fr);
    reset = r; sym_valid = sv; sym_data = sd; flush = fl; frame_ready = fr;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic fv, input logic [29:0] b, input logic [3:0] c, input logic o);
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(fv));
    chk({tag, ".dct_buffer"}, 32'(dct_buffer), 32'(b));
    chk({tag, ".dct_count"}, 32'(dct_count), 32'(c));
    chk({tag, ".overflow"}, 32'(overflow), 32'(o));
  endtask
  initial begin
    reset = 1; sym_valid = 0; sym_data = 0; flush = 0; frame_ready = 0;
    tbl[0]  = '{1, 0, 0, 0, 1, 0, 30'h0,  0, 0};
    tbl[1]  = '{0, 1, 3, 0, 1, 0, 30'h0,  0, 0};
    tbl[2]  = '{0, 1, 2, 0, 1, 0, 30'h0,  0, 0};
    tbl[3]  = '{0, 1, 1, 0, 1, 0, 30'h0,  0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 1, 30'h39, 3, 0};
    tbl[5]  = '{0, 0, 0, 0, 1, 0, 30'h39, 3, 0};
    tbl[6]  = '{0, 0, 0, 1, 1, 0, 30'h39, 3, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 0, 30'h39, 3, 0};
    tbl[8]  = '{0, 1, 2, 1, 1, 1, 30'h2,  1, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 0, 30'h2,  1, 0};
    tbl[10] = '{0, 1, 3, 0, 0, 0, 30'h2,  1, 0};
    tbl[11] = '{0, 0, 0, 1, 0, 1, 30'h3,  1, 0};
    tbl[12] = '{0, 1, 1, 1, 0, 1, 30'h3,  1, 0};
    tbl[13] = '{0, 1, 2, 0, 0, 1, 30'h3,  1, 0};
    tbl[14] = '{0, 0, 0, 0, 1, 1, 30'h6,  2, 0};
    tbl[15] = '{0, 0, 0, 0, 1, 0, 30'h6,  2, 0};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].sv, tbl[i].sd, tbl[i].fl, tbl[i].fr);
      chk_out($sformatf("vec%0d", i), tbl[i].fv, tbl[i].buff, tbl[i].cnt, tbl[i].ovf);
    end
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 2'((i + 1) % 4), 0, 1);
      if (i < 14) chk($sformatf("full.early_fv%0d", i), 32'(frame_valid), 0);
    end
    chk_out("full", 1, 30'h1B1B1B1B, 15, 0);
    step(0, 0, 0, 0, 1);
    chk("full.release", 32'(frame_valid), 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 2'((i + 1) % 4), 0, 0);
    chk_out("hold", 1, 30'h1B1B1B1B, 15, 0);
    step(0, 1, 2'd3, 0, 0);
    chk_out("drop", 1, 30'h1B1B1B1B, 15, 1);
    step(0, 0, 0, 0, 1);
    chk_out("b2b", 1, 30'h06C6C6C6, 15, 1);
    step(0, 0, 0, 0, 1);
    chk_out("b2b_end", 0, 30'h06C6C6C6, 15, 1);
    for (int i = 0; i < 22; i++) step(0, 1, 2'((i + 1) % 4), 0, 0);
    chk("mid.fv", 32'(frame_valid), 1);
    step(1, 0, 0, 0, 1);
    chk_out("rst_mid", 0, 30'h0, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("rst_flush", 32'(frame_valid), 0);
    step(0, 0, 0, 0, 1);
    chk("rst_flush2", 32'(frame_valid), 0);
`ifdef DCT_PACK_STATS_EN
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 33; i++) step(0, 1, 2'(i % 4), 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 1);
    step(0, 1, 2, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("stats.drop_count", 32'(drop_count), 3);
    chk("stats.frame_total", 32'(frame_total), 4);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
